// File: rtl/tiny16_runctl_if.sv
// Control/status bundle between tiny16_runctl and its core/host side.
// The controller uses the slave view; the core side uses the master view.
interface tiny16_runctl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             halt;
  logic [7:0]       out_data;
  logic             cpu_rst;
  logic             cpu_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycles;
  logic [15:0]      out_count;
  logic [15:0]      sig;

  modport master (
    output start, halt, out_data,
    input  cpu_rst, cpu_en, busy, done, timeout, cycles, out_count, sig
  );

  modport slave (
    input  start, halt, out_data,
    output cpu_rst, cpu_en, busy, done, timeout, cycles, out_count, sig
  );
endinterface

// File: rtl/tiny16_runctl.sv
// Run controller for the tiny16 core: core reset sequencing, bounded run window,
// halt/budget stop and a 16-bit signature of OUT port activity.
module tiny16_runctl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned RUN_CYCLES = 2048,
  parameter int unsigned CNT_W      = 16,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  tiny16_runctl_if.slave bus
);

  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned BW  = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES + 1) : 1;
  localparam logic [RcW-1:0] RstLast    = RcW'(RST_CYCLES - 1);
  localparam logic [BW-1:0]  BudgetLast = BW'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [RcW-1:0]   rcnt_q;
  logic [BW-1:0]    bcnt_q;
  logic [CNT_W-1:0] cycles_q;
  logic [15:0]      out_count_q;
  logic [15:0]      sig_q;
  logic [7:0]       prev_q;
  logic             timeout_q;
  logic             auto_pend_q;
  logic             rst_d1_q;

  logic        auto_go;
  logic        budget_hit;
  logic        enter_reset;
  logic        out_changed;
  logic [15:0] sig_step;

  // Autostart waits one full idle cycle after reset release.
  assign auto_go     = auto_pend_q && !rst_d1_q;
  assign budget_hit  = (RUN_CYCLES != 0) && (bcnt_q == BudgetLast);
  assign enter_reset = (state_q != StReset) && (state_d == StReset);
  assign out_changed = (bus.out_data != prev_q);
  assign sig_step    = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                       ^ {8'h00, bus.out_data};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start || auto_go) state_d = StReset;
      StReset: if (rcnt_q == RstLast) state_d = StRun;
      StRun:   if (bus.halt || budget_hit) state_d = StDone;
      StDone:  if (bus.start) state_d = StReset;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cpu_rst = 1'b0;
    bus.cpu_en  = 1'b0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    unique case (state_q)
      StIdle:  bus.cpu_rst = 1'b1;
      StReset: begin
        bus.cpu_rst = 1'b1;
        bus.busy    = 1'b1;
      end
      StRun: begin
        bus.cpu_en = 1'b1;
        bus.busy   = 1'b1;
      end
      StDone:  bus.done = 1'b1;
      default: bus.cpu_rst = 1'b1;
    endcase
  end

  assign bus.timeout   = timeout_q;
  assign bus.cycles    = cycles_q;
  assign bus.out_count = out_count_q;
  assign bus.sig       = sig_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rcnt_q      <= '0;
      bcnt_q      <= '0;
      cycles_q    <= '0;
      out_count_q <= '0;
      sig_q       <= '0;
      prev_q      <= '0;
      timeout_q   <= 1'b0;
      auto_pend_q <= AUTO_START;
      rst_d1_q    <= 1'b1;
    end else begin
      rst_d1_q <= 1'b0;
      if (state_d != StIdle) auto_pend_q <= 1'b0;
      if (enter_reset) begin
        rcnt_q      <= '0;
        bcnt_q      <= '0;
        cycles_q    <= '0;
        out_count_q <= '0;
        sig_q       <= '0;
        prev_q      <= '0;
        timeout_q   <= 1'b0;
      end else if (state_q == StReset) begin
        rcnt_q <= rcnt_q + 1'b1;
      end else if (state_q == StRun) begin
        bcnt_q <= bcnt_q + 1'b1;
        if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
        if (out_changed) begin
          sig_q  <= sig_step;
          prev_q <= bus.out_data;
          if (out_count_q != '1) out_count_q <= out_count_q + 1'b1;
        end
        // Halt takes priority over budget expiry on the same cycle.
        if (state_d == StDone) timeout_q <= ~bus.halt;
      end
    end
  end

endmodule

// File: tb/tb_tiny16_runctl.sv
// Bench for tiny16_runctl: randomized runs checked against a run-level model,
// plus an unlimited-budget instance with a 4-bit cycle counter.
module tb_tiny16_runctl;
  localparam int unsigned RstC = 4;
  localparam int unsigned RunC = 16;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] vals[$];

  tiny16_runctl_if #(.CNT_W(16)) bus_a ();
  tiny16_runctl_if #(.CNT_W(4))  bus_b ();

  tiny16_runctl #(
    .RST_CYCLES(RstC), .RUN_CYCLES(RunC), .CNT_W(16), .AUTO_START(1'b1)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .bus(bus_a)
  );

  tiny16_runctl #(
    .RST_CYCLES(RstC), .RUN_CYCLES(0), .CNT_W(4), .AUTO_START(1'b0)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Signature of the sequence of distinct OUT values seen during a run.
  function automatic logic [15:0] sig_of(input logic [7:0] q[$]);
    logic [15:0] s;
    s = 16'h0000;
    foreach (q[k]) s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {8'h00, q[k]};
    return s;
  endfunction

  task automatic chk_reset_a(input string tag);
    check_eq({tag, "_cpu_rst"}, bus_a.cpu_rst, 1);
    check_eq({tag, "_cpu_en"}, bus_a.cpu_en, 0);
    check_eq({tag, "_busy"}, bus_a.busy, 0);
    check_eq({tag, "_done"}, bus_a.done, 0);
    check_eq({tag, "_timeout"}, bus_a.timeout, 0);
    check_eq({tag, "_cycles"}, bus_a.cycles, 0);
    check_eq({tag, "_out_count"}, bus_a.out_count, 0);
    check_eq({tag, "_sig"}, bus_a.sig, 0);
  endtask

  task automatic fill_random();
    logic [7:0] v;
    v = 8'h00;
    vals.delete();
    for (int i = 0; i < int'(RunC); i++) begin
      if ($urandom_range(0, 2) == 0) v = 8'($urandom);
      vals.push_back(v);
    end
  endtask

  // Entry: at a negedge, next posedge moves DUT A into RESET (start or autostart).
  task automatic do_run(input int halt_at);
    int         len;
    bit         to;
    logic [7:0] chg[$];
    logic [7:0] last;
    bit         halted;
    halted = (halt_at >= 1) && (halt_at <= int'(RunC));
    len    = halted ? halt_at : int'(RunC);
    to     = !halted;
    last   = 8'h00;
    for (int r = 1; r <= int'(RstC); r++) begin
      @(posedge clk); @(negedge clk);
      bus_a.start = 1'b0;
      check_eq("rst_cpu_rst", bus_a.cpu_rst, 1);
      check_eq("rst_cpu_en", bus_a.cpu_en, 0);
      check_eq("rst_busy", bus_a.busy, 1);
      check_eq("rst_cycles", bus_a.cycles, 0);
      check_eq("rst_sig", bus_a.sig, 0);
      check_eq("rst_out_count", bus_a.out_count, 0);
      check_eq("rst_timeout", bus_a.timeout, 0);
      // Junk on START/HALT/OUT_DATA while in RESET must be ignored.
      bus_a.out_data = 8'($urandom);
      bus_a.halt     = 1'($urandom_range(0, 1));
      bus_a.start    = (r < int'(RstC)) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    for (int i = 1; i <= len; i++) begin
      @(posedge clk); @(negedge clk);
      bus_a.start = 1'b0;
      check_eq("run_cpu_en", bus_a.cpu_en, 1);
      check_eq("run_cpu_rst", bus_a.cpu_rst, 0);
      check_eq("run_done", bus_a.done, 0);
      check_eq("run_cycles", bus_a.cycles, i - 1);
      check_eq("run_sig", bus_a.sig, sig_of(chg));
      check_eq("run_out_count", bus_a.out_count, chg.size());
      bus_a.out_data = vals[i-1];
      bus_a.halt     = (i == halt_at);
      bus_a.start    = 1'($urandom_range(0, 1));
      if (vals[i-1] != last) begin
        chg.push_back(vals[i-1]);
        last = vals[i-1];
      end
    end
    @(posedge clk); @(negedge clk);
    bus_a.halt  = 1'b0;
    bus_a.start = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check_eq("done_done", bus_a.done, 1);
      check_eq("done_cpu_en", bus_a.cpu_en, 0);
      check_eq("done_cpu_rst", bus_a.cpu_rst, 0);
      check_eq("done_busy", bus_a.busy, 0);
      check_eq("done_timeout", bus_a.timeout, to);
      check_eq("done_cycles", bus_a.cycles, len);
      check_eq("done_sig", bus_a.sig, sig_of(chg));
      check_eq("done_out_count", bus_a.out_count, chg.size());
      bus_a.out_data = 8'($urandom);
      bus_a.halt     = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
    end
    bus_a.halt = 1'b0;
  endtask

  initial begin
    logic [7:0] pre[$];
    int         h;
    bus_a.start = 1'b0; bus_a.halt = 1'b0; bus_a.out_data = 8'h00;
    bus_b.start = 1'b0; bus_b.halt = 1'b0; bus_b.out_data = 8'h00;

    // Power-on reset then autostart; all-zero OUT gives timeout with empty signature.
    rst_a = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_reset_a("por");
    rst_a = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("idle_cpu_rst", bus_a.cpu_rst, 1);
    check_eq("idle_busy", bus_a.busy, 0);
    vals.delete();
    for (int i = 0; i < int'(RunC); i++) vals.push_back(8'h00);
    do_run(0);

    fill_random();
    bus_a.start = 1'b1;
    do_run(5);

    // Fixed signature pattern, run twice.
    for (int rep = 0; rep < 2; rep++) begin
      vals.delete();
      for (int i = 0; i < int'(RunC); i++) vals.push_back(i == 0 ? 8'h00 : (i < 5 ? 8'h5A : 8'h3C));
      bus_a.start = 1'b1;
      do_run(0);
      check_eq("sig_pattern", bus_a.sig, 16'h0088);
      check_eq("sig_pattern_count", bus_a.out_count, 2);
    end

    fill_random();
    bus_a.start = 1'b1;
    do_run(RunC);

    for (int k = 0; k < 6; k++) begin
      fill_random();
      case ($urandom_range(0, 3))
        0:       h = 0;
        1:       h = RunC;
        default: h = $urandom_range(1, RunC);
      endcase
      bus_a.start = 1'b1;
      do_run(h);
    end

    // Reset in the middle of a run, then autostart again.
    bus_a.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_a.start = 1'b0;
    repeat (RstC) @(posedge clk);
    @(negedge clk);
    bus_a.out_data = 8'hA5;
    @(posedge clk); @(negedge clk);
    bus_a.out_data = 8'h3C;
    @(posedge clk); @(negedge clk);
    pre.delete();
    pre.push_back(8'hA5);
    pre.push_back(8'h3C);
    check_eq("mid_cpu_en", bus_a.cpu_en, 1);
    check_eq("mid_sig", bus_a.sig, sig_of(pre));
    rst_a = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_reset_a("midrst");
    rst_a = 1'b0;
    bus_a.out_data = 8'h00;
    @(posedge clk); @(negedge clk);
    check_eq("mid_idle_busy", bus_a.busy, 0);
    fill_random();
    do_run($urandom_range(0, RunC));

    // Unlimited budget, 4-bit counter, no autostart.
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("b_idle_busy", bus_b.busy, 0);
    check_eq("b_idle_cpu_rst", bus_b.cpu_rst, 1);
    bus_b.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_b.start = 1'b0;
    check_eq("b_reset_busy", bus_b.busy, 1);
    repeat (RstC) @(posedge clk);
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      check_eq("b_run_cpu_en", bus_b.cpu_en, 1);
      check_eq("b_run_cycles", bus_b.cycles, (i - 1 > 15) ? 15 : i - 1);
      bus_b.halt = (i == 20);
      @(posedge clk); @(negedge clk);
    end
    bus_b.halt = 1'b0;
    check_eq("b_done", bus_b.done, 1);
    check_eq("b_timeout", bus_b.timeout, 0);
    check_eq("b_cycles_sat", bus_b.cycles, 4'hF);
    check_eq("b_cpu_en", bus_b.cpu_en, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
